exec_seq: RTL and testbench
===========================

EXEC_SEQ -- requirements
Module: exec_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the ports cmd_valid (input, 1) and cmd_ready (output, 1): the command handshake.
REQ-004 The block SHALL have the ports cmd_op, cmd_rd, cmd_rs, cmd_rt and cmd_imm, each input, 4 bits: opcode, destination register, source registers, shift amount.
REQ-005 The block SHALL have the ports rf_src1 and rf_src2 (output, 4) and rf_data1 and rf_data2 (input, 16): register-file read address and combinational read data.
REQ-006 The block SHALL have the ports rf_wen (output, 1), rf_dst (output, 4) and rf_wdata (output, 16): register-file write port.
REQ-007 The block SHALL have the ports fu_a and fu_b (output, 16), fu_sel (output, 2; 0=ADDSUB 1=XOR 2=RED 3=SHIFT), fu_sub (output, 1) and fu_mode (output, 2; 0=SLL 1=SRA 2=ROR).
REQ-008 The block SHALL have the ports fu_result (input, 16) and fu_ovfl (input, 1): functional-unit result and saturation/overflow indication.
REQ-009 The block SHALL have the ports flags (output, 3: Z, V, N), busy (output, 1), done (output, 1; one-cycle pulse) and err (output, 1; one-cycle pulse).

Function
REQ-010 The block SHALL implement the states IDLE, READ, EXEC and WB, with sequence IDLE->READ->EXEC->WB->IDLE.
REQ-011 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid and cmd_ready both 1, and all cmd_* fields are latched at that edge.
REQ-012 Opcodes SHALL be: 0 ADD, 1 SUB, 2 XOR, 3 RED, 4 SLL, 5 SRA, 6 ROR; opcodes 7-15 are illegal.
REQ-013 An illegal opcode SHALL be accepted and consumed, pulse err in the following cycle, stay in IDLE, and cause no write and no flag change.
REQ-014 In READ, rf_src1=rs and rf_src2=rt; rf_data1/rf_data2 SHALL be registered into operand registers at the end of READ.
REQ-015 In EXEC, fu_a SHALL be operand1 and fu_b SHALL be operand2 (shifts: fu_b={12'b0,imm}); fu_sel, fu_sub and fu_mode SHALL be decoded from the opcode; fu_result and fu_ovfl are registered at the end of EXEC.
REQ-016 Outside EXEC, fu_a, fu_b, fu_sel, fu_sub and fu_mode SHALL be 0.
REQ-017 In WB, rf_wen=1 for exactly one cycle with rf_dst=rd and rf_wdata=the registered result; if rd=0, rf_wen SHALL remain 0 (R0 is hardwired zero).
REQ-018 done SHALL pulse during the WB cycle, including when rd=0.
REQ-019 Latency: for an accept at edge N, rf_wen SHALL be high in the cycle after edge N+2, and cmd_ready SHALL return after edge N+3 (one command per 4 cycles).
REQ-020 Flags SHALL update at the end of WB: ADD/SUB update Z (result==0), V (fu_ovfl) and N (result[15]); XOR/SLL/SRA/ROR update Z only; RED updates none.
REQ-021 busy SHALL equal (state != IDLE).
REQ-022 A command held on cmd_valid while busy SHALL be ignored until IDLE, then accepted on the first IDLE edge.

Reset
REQ-023 When rst_n is 0, the block SHALL immediately force state to IDLE and all outputs, flags and operand/result registers to 0, except cmd_ready, which is 1 while rst_n is 1 and in IDLE, and 0 while rst_n is 0.
REQ-024 Reset mid-operation SHALL discard the in-flight command with no write; the first accept is on the first rising edge after rst_n rises.

Structure
REQ-025 Package exec_seq_pkg SHALL hold the opcode enum, the state enum and the fu_sel/fu_mode encodings.
REQ-026 One combinational sub-module, exec_decode (opcode -> fu_sel, fu_sub, fu_mode, flag-update mask, illegal), SHALL be instantiated.

Verification
REQ-027 Reset then ADD: with R1=0x7FFF, R2=0x0001, ADD rd=3 rs=1 rt=2 -> rf_wen in the third cycle after accept, rf_dst=3, rf_wdata=fu_result (0x7FFF saturated), flags V=1, N=0, Z=0.
REQ-028 SUB: rs value 0x0005, rt value 0x0005 -> rf_wdata=0x0000, Z=1, V=0, N=0; done pulses once.
REQ-029 SLL with rs value 0xAAAA, imm=5 -> fu_sel=3, fu_mode=0, fu_b=0x0005 during EXEC; flags: only Z changes; prior V/N are preserved.
REQ-030 Illegal opcode 0xF -> err pulses one cycle, no rf_wen, busy stays 0, flags unchanged; an ADD with rd=0 -> done pulses and rf_wen stays 0.
REQ-031 Back-to-back: cmd_valid held high with two commands -> accepts 4 cycles apart, cmd_ready=0 while busy; rst_n pulsed low during EXEC -> no rf_wen, outputs 0, flags 0.

Source files
------------

// File: rtl/exec_seq_pkg.sv
// exec_seq_pkg: opcode, state and functional-unit encodings shared by the sequencer
package exec_seq_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_XOR = 4'd2,
    OP_RED = 4'd3,
    OP_SLL = 4'd4,
    OP_SRA = 4'd5,
    OP_ROR = 4'd6
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;
  typedef enum logic [1:0] {SEL_ADDSUB, SEL_XOR, SEL_RED, SEL_SHIFT} sel_e;
  typedef enum logic [1:0] {MODE_SLL, MODE_SRA, MODE_ROR} mode_e;
  localparam logic [2:0] FM_ALL  = 3'b111;
  localparam logic [2:0] FM_Z    = 3'b100;
  localparam logic [2:0] FM_NONE = 3'b000;
endpackage

// File: rtl/exec_decode.sv
// exec_decode: opcode to functional-unit controls, flag-update mask {Z,V,N} and illegal flag
module exec_decode
  import exec_seq_pkg::*;
(
  input  logic [3:0] op_i,
  output logic [1:0] sel_o,
  output logic       sub_o,
  output logic [1:0] mode_o,
  output logic [2:0] fmask_o,
  output logic       illegal_o
);
  logic as;
  always_comb begin
    as        = op_i == OP_ADD || op_i == OP_SUB;
    illegal_o = op_i > OP_ROR;
    sel_o     = as ? SEL_ADDSUB : op_i == OP_XOR ? SEL_XOR : op_i == OP_RED ? SEL_RED :
                illegal_o ? SEL_ADDSUB : SEL_SHIFT;
    sub_o     = op_i == OP_SUB;
    mode_o    = op_i == OP_SRA ? MODE_SRA : op_i == OP_ROR ? MODE_ROR : MODE_SLL;
    fmask_o   = illegal_o ? FM_NONE : as ? FM_ALL : op_i == OP_RED ? FM_NONE : FM_Z;
  end
endmodule

// File: rtl/exec_seq.sv
// exec_seq: four-state read/execute/writeback sequencer driving a register file and functional unit
module exec_seq
  import exec_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [3:0]  cmd_rd,
  input  logic [3:0]  cmd_rs,
  input  logic [3:0]  cmd_rt,
  input  logic [3:0]  cmd_imm,
  output logic [3:0]  rf_src1,
  output logic [3:0]  rf_src2,
  input  logic [15:0] rf_data1,
  input  logic [15:0] rf_data2,
  output logic        rf_wen,
  output logic [3:0]  rf_dst,
  output logic [15:0] rf_wdata,
  output logic [15:0] fu_a,
  output logic [15:0] fu_b,
  output logic [1:0]  fu_sel,
  output logic        fu_sub,
  output logic [1:0]  fu_mode,
  input  logic [15:0] fu_result,
  input  logic        fu_ovfl,
  output logic [2:0]  flags,
  output logic        busy,
  output logic        done,
  output logic        err
);
  state_e      state_q, state_d;
  logic [3:0]  op_q, rd_q, rs_q, rt_q, imm_q, dec_op;
  logic [15:0] opa_q, opb_q, res_q;
  logic        ovfl_q, err_q, accept, ex, wb;
  logic [2:0]  flags_q, flags_d, fmask;
  logic [1:0]  sel, mode;
  logic        sub, illegal;
  assign dec_op = state_q == S_IDLE ? cmd_op : op_q;
  exec_decode u_dec (
    .op_i     (dec_op),
    .sel_o    (sel),
    .sub_o    (sub),
    .mode_o   (mode),
    .fmask_o  (fmask),
    .illegal_o(illegal)
  );
  always_comb begin
    cmd_ready = rst_n && state_q == S_IDLE;
    accept    = cmd_valid && cmd_ready;
    ex        = state_q == S_EXEC;
    wb        = state_q == S_WB;
    state_d   = state_q == S_IDLE ? (accept && !illegal ? S_READ : S_IDLE) :
                state_q == S_READ ? S_EXEC : state_q == S_EXEC ? S_WB : S_IDLE;
    flags_d   = wb ? {fmask[2] ? res_q == 16'h0 : flags_q[2],
                      fmask[1] ? ovfl_q : flags_q[1],
                      fmask[0] ? res_q[15] : flags_q[0]} : flags_q;
    busy      = state_q != S_IDLE;
    rf_src1   = state_q == S_READ ? rs_q : 4'd0;
    rf_src2   = state_q == S_READ ? rt_q : 4'd0;
    fu_a      = ex ? opa_q : 16'h0;
    fu_b      = ex ? (sel == SEL_SHIFT ? {12'h0, imm_q} : opb_q) : 16'h0;
    fu_sel    = ex ? sel : 2'd0;
    fu_sub    = ex && sub;
    fu_mode   = ex ? mode : 2'd0;
    rf_wen    = wb && rd_q != 4'd0;
    rf_dst    = wb ? rd_q : 4'd0;
    rf_wdata  = wb ? res_q : 16'h0;
    done      = wb;
    err       = err_q;
    flags     = flags_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      {op_q, rd_q, rs_q, rt_q, imm_q} <= '0;
      {opa_q, opb_q, res_q, ovfl_q} <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      err_q   <= accept && illegal;
      if (accept) {op_q, rd_q, rs_q, rt_q, imm_q} <= {cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm};
      if (state_q == S_READ) {opa_q, opb_q} <= {rf_data1, rf_data2};
      if (ex) {res_q, ovfl_q} <= {fu_result, fu_ovfl};
    end
  end
endmodule

// File: tb/tb_exec_seq.sv
// tb_exec_seq: scoreboard bench for exec_seq with register-file and functional-unit models
module tb_exec_seq;
  logic        clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_op = '0, cmd_rd = '0, cmd_rs = '0, cmd_rt = '0, cmd_imm = '0;
  logic [3:0]  rf_src1, rf_src2, rf_dst;
  logic [15:0] rf_data1, rf_data2, rf_wdata, fu_a, fu_b, fu_result;
  logic        rf_wen, fu_sub, fu_ovfl, busy, done, err;
  logic [1:0]  fu_sel, fu_mode;
  logic [2:0]  flags;
  logic [15:0] rf [16];
  int          total = 0, bad = 0, wen_cnt = 0, wc;
  typedef struct packed {
    logic        is_err;
    logic        wen;
    logic [3:0]  dst;
    logic [15:0] wdata;
    logic [2:0]  fl;
  } exp_t;
  exp_t q[$];
  exp_t e;
  always #5 clk = ~clk;
  exec_seq dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_imm(cmd_imm),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rf_wen(rf_wen), .rf_dst(rf_dst), .rf_wdata(rf_wdata),
    .fu_a(fu_a), .fu_b(fu_b), .fu_sel(fu_sel), .fu_sub(fu_sub), .fu_mode(fu_mode),
    .fu_result(fu_result), .fu_ovfl(fu_ovfl),
    .flags(flags), .busy(busy), .done(done), .err(err)
  );
  assign rf_data1 = rf[rf_src1];
  assign rf_data2 = rf[rf_src2];
  always @(posedge clk) if (rf_wen) begin
    rf[rf_dst] <= rf_wdata;
    wen_cnt <= wen_cnt + 1;
  end
  logic signed [16:0] s;
  logic [31:0] rot;
  always_comb begin
    s = fu_sub ? $signed({fu_a[15], fu_a}) - $signed({fu_b[15], fu_b})
               : $signed({fu_a[15], fu_a}) + $signed({fu_b[15], fu_b});
    rot = {fu_a, fu_a} >> fu_b[3:0];
    fu_ovfl = 1'b0;
    fu_result = 16'h0;
    if (fu_sel == 2'd0) begin
      fu_ovfl = s[16] != s[15];
      fu_result = fu_ovfl ? (s[16] ? 16'h8000 : 16'h7FFF) : s[15:0];
    end else if (fu_sel == 2'd1) fu_result = fu_a ^ fu_b;
    else if (fu_sel == 2'd2) fu_result = {15'h0, ^fu_a};
    else fu_result = fu_mode == 2'd0 ? fu_a << fu_b[3:0] :
                     fu_mode == 2'd1 ? 16'($signed(fu_a) >>> fu_b[3:0]) : rot[15:0];
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, x);
    end
  endtask
  task automatic push(input logic is_err, input logic wen, input logic [3:0] dst,
                      input logic [15:0] wdata, input logic [2:0] fl);
    q.push_back({is_err, wen, dst, wdata, fl});
  endtask
  task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                      input logic [3:0] rt, input logic [3:0] imm);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 0, 1);
    {cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm} = {op, rd, rs, rt, imm};
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask
  task automatic watch(input logic [3:0] rs, input logic [3:0] rt, input logic [1:0] sel,
                       input logic [1:0] mode, input logic sub, input logic [15:0] a,
                       input logic [15:0] b, input logic wen);
    @(negedge clk);
    chk("read_src", {busy, cmd_ready, rf_src1, rf_src2}, {1'b1, 1'b0, rs, rt});
    chk("read_fu_zero", {fu_a, fu_b, fu_sel, fu_sub, fu_mode}, 0);
    @(negedge clk);
    chk("exec_fu", {fu_sel, fu_mode, fu_sub, fu_a, fu_b}, {sel, mode, sub, a, b});
    chk("exec_no_wen", {rf_wen, done}, 0);
    @(negedge clk);
    chk("wb_wen_done", {rf_wen, done, cmd_ready}, {wen, 1'b1, 1'b0});
    @(negedge clk);
    chk("idle_ready", {cmd_ready, busy, done, rf_wen}, 4'b1000);
  endtask
  always @(negedge clk) begin
    if (rst_n && (done || err)) begin
      if (q.size() == 0) chk("unexpected_event", {done, err}, 0);
      else begin
        e = q.pop_front();
        chk("event_kind", {done, err}, e.is_err ? 2'b01 : 2'b10);
        if (!e.is_err) begin
          chk("rf_wen", rf_wen, e.wen);
          chk("rf_dst", rf_dst, e.dst);
          chk("rf_wdata", rf_wdata, e.wdata);
        end
        @(posedge clk);
        #1 chk("flags", flags, e.fl);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
    rf[1] = 16'h7FFF; rf[2] = 16'h0001; rf[4] = 16'hAAAA; rf[5] = 16'h0005;
    rf[6] = 16'hFFFF; rf[7] = 16'h0007; rf[8] = 16'h00FF; rf[9] = 16'h8000;
    rf[10] = 16'h0001;
    #2;
    chk("reset_outputs", {cmd_ready, busy, done, err, rf_wen, flags, fu_a, fu_sel, rf_src1}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {cmd_ready, busy}, 2'b10);
    push(0, 1, 4'd3, 16'h7FFF, 3'b010);
    send(4'd0, 4'd3, 4'd1, 4'd2, 4'd0);
    watch(4'd1, 4'd2, 2'd0, 2'd0, 1'b0, 16'h7FFF, 16'h0001, 1'b1);
    push(0, 1, 4'd11, 16'h5540, 3'b010);
    send(4'd4, 4'd11, 4'd4, 4'd5, 4'd5);
    watch(4'd4, 4'd5, 2'd3, 2'd0, 1'b0, 16'hAAAA, 16'h0005, 1'b1);
    push(0, 1, 4'd12, 16'h0000, 3'b100);
    send(4'd1, 4'd12, 4'd5, 4'd5, 4'd0);
    watch(4'd5, 4'd5, 2'd0, 2'd0, 1'b1, 16'h0005, 16'h0005, 1'b1);
    push(1, 0, 4'd0, 16'h0, 3'b100);
    send(4'd15, 4'd9, 4'd1, 4'd2, 4'd0);
    @(negedge clk);
    chk("illegal_err", {err, busy, cmd_ready, rf_wen}, 4'b1010);
    @(negedge clk);
    chk("illegal_err_once", {err, busy}, 2'b00);
    push(0, 0, 4'd0, 16'hFFFE, 3'b001);
    send(4'd0, 4'd0, 4'd6, 4'd6, 4'd0);
    watch(4'd6, 4'd6, 2'd0, 2'd0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
    push(0, 1, 4'd13, 16'h0001, 3'b001);
    send(4'd3, 4'd13, 4'd7, 4'd0, 4'd0);
    watch(4'd7, 4'd0, 2'd2, 2'd0, 1'b0, 16'h0007, 16'h0000, 1'b1);
    push(0, 1, 4'd14, 16'h0000, 3'b101);
    send(4'd2, 4'd14, 4'd8, 4'd8, 4'd0);
    watch(4'd8, 4'd8, 2'd1, 2'd0, 1'b0, 16'h00FF, 16'h00FF, 1'b1);
    push(0, 1, 4'd15, 16'hF000, 3'b001);
    send(4'd5, 4'd15, 4'd9, 4'd0, 4'd3);
    watch(4'd9, 4'd0, 2'd3, 2'd1, 1'b0, 16'h8000, 16'h0003, 1'b1);
    push(0, 1, 4'd13, 16'h8000, 3'b001);
    send(4'd6, 4'd13, 4'd10, 4'd0, 4'd1);
    watch(4'd10, 4'd0, 2'd3, 2'd2, 1'b0, 16'h0001, 16'h0001, 1'b1);
    push(0, 1, 4'd14, 16'h0002, 3'b000);
    push(0, 1, 4'd15, 16'h7FFE, 3'b000);
    @(negedge clk);
    {cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm} = {4'd0, 4'd14, 4'd2, 4'd2, 4'd0};
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 {cmd_op, cmd_rd, cmd_rs, cmd_rt} = {4'd2, 4'd15, 4'd1, 4'd2};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_busy", {cmd_ready, busy}, 2'b01);
    end
    @(negedge clk);
    chk("b2b_ready_4th", {cmd_ready, busy}, 2'b10);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("b2b_second_accept", busy, 1'b1);
    repeat (4) @(negedge clk);
    chk("b2b_idle", {cmd_ready, busy}, 2'b10);
    wc = wen_cnt;
    send(4'd0, 4'd13, 4'd1, 4'd2, 4'd0);
    repeat (2) @(negedge clk);
    chk("pre_reset_exec", {busy, fu_a}, {1'b1, 16'h7FFF});
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {cmd_ready, busy, done, err, rf_wen, flags, fu_a, fu_b, fu_sel, rf_dst, rf_wdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_write", wen_cnt, wc);
    chk("midrst_state", {flags, busy, cmd_ready}, 5'b00001);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
